// File: rtl/fc_neuron_feeder_if.sv
// Beat-stream bundle between the neuron feeder, its feature/weight memories and the neuron.
// The master side is the feeder itself; the slave side is the surrounding memories and neuron.
interface fc_neuron_feeder_if #(
    parameter int IN_SIZE   = 10,
    parameter int NEURON_NB = 64,
    parameter int NUM_NEUR  = 16,
    parameter int WIDTH     = 16
);
    localparam int NUM_BEATS = (NEURON_NB + IN_SIZE - 1) / IN_SIZE;
    localparam int SEL_W     = $clog2(NUM_NEUR);
    localparam int WA_W      = $clog2(NUM_NEUR * NUM_BEATS);

    logic                           start;
    logic [SEL_W-1:0]               neuron_sel;
    logic                           hold;
    logic [2:0]                     feat_addr;
    logic [IN_SIZE-1:0][WIDTH-1:0]  feat_data;
    logic [WA_W-1:0]                wgt_addr;
    logic [IN_SIZE-1:0][WIDTH-1:0]  wgt_data;
    logic                           en;
    logic [2:0]                     addr;
    logic [IN_SIZE-1:0][WIDTH-1:0]  in_data;
    logic [IN_SIZE-1:0][WIDTH-1:0]  weight;
    logic                           full_data;
    logic                           busy;
    logic                           done;

    modport master (
        input  start, neuron_sel, hold, feat_data, wgt_data,
        output feat_addr, wgt_addr, en, addr, in_data, weight, full_data, busy, done
    );

    modport slave (
        output start, neuron_sel, hold, feat_data, wgt_data,
        input  feat_addr, wgt_addr, en, addr, in_data, weight, full_data, busy, done
    );
endinterface

// File: rtl/fc_neuron_feeder.sv
// Sequencer that streams one neuron's feature vector and weight row as IN_SIZE-lane beats,
// then pulses full_data after the processing-unit pipeline drains. DRAIN must be at least 1.
module fc_neuron_feeder #(
    parameter int IN_SIZE   = 10,
    parameter int NEURON_NB = 64,
    parameter int NUM_NEUR  = 16,
    parameter int WIDTH     = 16,
    parameter int DRAIN     = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    fc_neuron_feeder_if.master      bus
);
    localparam int NUM_BEATS = (NEURON_NB + IN_SIZE - 1) / IN_SIZE;
    localparam int SEL_W     = $clog2(NUM_NEUR);
    localparam int WA_W      = $clog2(NUM_NEUR * NUM_BEATS);
    localparam int DC_W      = (DRAIN > 1) ? $clog2(DRAIN) : 1;
    localparam logic [2:0]      LAST_BEAT = 3'(NUM_BEATS - 1);
    localparam logic [DC_W-1:0] LAST_DRAIN = DC_W'(DRAIN - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_WAIT, S_DRAIN, S_FULL, S_DONE
    } state_t;

    state_t                         state_reg, state_next;
    logic [2:0]                     beat_cnt_reg;
    logic [SEL_W-1:0]               sel_reg;
    logic                           issue;
    logic                           issue_q_reg;
    logic [2:0]                     beat_q_reg;
    logic [DC_W-1:0]                drain_cnt_reg;
    logic                           en_reg;
    logic [2:0]                     addr_reg;
    logic [IN_SIZE-1:0][WIDTH-1:0]  in_data_reg;
    logic [IN_SIZE-1:0][WIDTH-1:0]  weight_reg;
    logic [IN_SIZE-1:0][WIDTH-1:0]  feat_masked;
    logic [IN_SIZE-1:0][WIDTH-1:0]  wgt_masked;

    always_comb begin
        state_next = state_reg;
        issue      = 1'b0;
        case (state_reg)
            S_IDLE:  if (bus.start) state_next = S_ISSUE;
            S_ISSUE: begin
                issue = ~bus.hold;
                if (issue && beat_cnt_reg == LAST_BEAT) state_next = S_WAIT;
            end
            // The final read is still in flight on entry; leave once it has been presented.
            S_WAIT:  if (!issue_q_reg) state_next = S_DRAIN;
            S_DRAIN: if (drain_cnt_reg == LAST_DRAIN) state_next = S_FULL;
            S_FULL:  state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= S_IDLE;
            beat_cnt_reg  <= '0;
            sel_reg       <= '0;
            issue_q_reg   <= 1'b0;
            beat_q_reg    <= '0;
            drain_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            issue_q_reg <= issue;
            if (state_reg == S_IDLE && bus.start) sel_reg <= bus.neuron_sel;
            if (issue) begin
                beat_q_reg   <= beat_cnt_reg;
                beat_cnt_reg <= (beat_cnt_reg == LAST_BEAT) ? 3'd0 : beat_cnt_reg + 3'd1;
            end
            if (state_reg == S_DRAIN && drain_cnt_reg != LAST_DRAIN)
                drain_cnt_reg <= drain_cnt_reg + DC_W'(1);
            else
                drain_cnt_reg <= '0;
        end
    end

    // Lanes past the end of the feature vector carry zeros so the neuron sum is unaffected.
    generate
        for (genvar gi = 0; gi < IN_SIZE; gi++) begin : g_lane
            logic lane_valid;
            assign lane_valid      = (int'(beat_q_reg) * IN_SIZE + gi) < NEURON_NB;
            assign feat_masked[gi] = lane_valid ? bus.feat_data[gi] : '0;
            assign wgt_masked[gi]  = lane_valid ? bus.wgt_data[gi]  : '0;
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            en_reg      <= 1'b0;
            addr_reg    <= '0;
            in_data_reg <= '0;
            weight_reg  <= '0;
        end else begin
            en_reg <= issue_q_reg;
            if (issue_q_reg) begin
                addr_reg    <= beat_q_reg;
                in_data_reg <= feat_masked;
                weight_reg  <= wgt_masked;
            end else begin
                in_data_reg <= '0;
                weight_reg  <= '0;
            end
        end
    end

    assign bus.feat_addr = beat_cnt_reg;
    assign bus.wgt_addr  = WA_W'(sel_reg) * WA_W'(NUM_BEATS) + WA_W'(beat_cnt_reg);
    assign bus.en        = en_reg;
    assign bus.addr      = addr_reg;
    assign bus.in_data   = in_data_reg;
    assign bus.weight    = weight_reg;
    assign bus.full_data = (state_reg == S_FULL);
    assign bus.done      = (state_reg == S_DONE);
    assign bus.busy      = (state_reg != S_IDLE);
endmodule

// File: tb/tb_fc_neuron_feeder.sv
// Scoreboard bench for fc_neuron_feeder: stimulus queues expected beats, a negedge monitor
// pops and compares each presented beat and checks drain spacing and pass termination.
module tb_fc_neuron_feeder;
    localparam int IN_SIZE   = 10;
    localparam int NEURON_NB = 64;
    localparam int NUM_NEUR  = 16;
    localparam int WIDTH     = 16;
    localparam int DRAIN     = 2;
    localparam int NUM_BEATS = 7;
    localparam int LW        = IN_SIZE * WIDTH;

    typedef logic [IN_SIZE-1:0][WIDTH-1:0] lanes_t;
    typedef struct {
        logic [2:0] addr;
        lanes_t     feat;
        lanes_t     wgt;
    } beat_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    fc_neuron_feeder_if #(.IN_SIZE(IN_SIZE), .NEURON_NB(NEURON_NB), .NUM_NEUR(NUM_NEUR),
                          .WIDTH(WIDTH)) bus ();

    fc_neuron_feeder #(.IN_SIZE(IN_SIZE), .NEURON_NB(NEURON_NB), .NUM_NEUR(NUM_NEUR),
                       .WIDTH(WIDTH), .DRAIN(DRAIN)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Synchronous wide memories: data valid one cycle after the address.
    lanes_t feat_mem [8];
    lanes_t wgt_mem  [128];
    always @(posedge clk) begin
        bus.feat_data <= feat_mem[bus.feat_addr];
        bus.wgt_data  <= wgt_mem[bus.wgt_addr];
    end

    int    checks = 0;
    int    errors = 0;
    beat_t exp_q [$];
    beat_t got;
    int    exp_span = 6;
    int    wgt_mode = 0;
    int    cyc = 0;
    int    first_en = -1;
    int    last_en = 0;
    int    en_in_pass = 0;
    int    full_cnt = 0;
    int    done_cnt = 0;
    bit    prev_full = 1'b0;

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic check_zero(input string name);
        chk({name, "_ctrl"}, LW'({bus.feat_addr, bus.wgt_addr, bus.en, bus.addr,
                                  bus.full_data, bus.busy, bus.done}), '0);
        chk({name, "_lanes"}, bus.in_data | bus.weight, '0);
    endtask

    task automatic fill_wgt(input int mode);
        wgt_mode = mode;
        for (int r = 0; r < 128; r++)
            for (int l = 0; l < IN_SIZE; l++)
                wgt_mem[r][l] = (mode == 0) ? 16'd1 : WIDTH'(r * 256 + l);
    endtask

    task automatic push_pass(input int sel);
        beat_t x;
        for (int b = 0; b < NUM_BEATS; b++) begin
            x.addr = 3'(b);
            for (int l = 0; l < IN_SIZE; l++) begin
                if (b * IN_SIZE + l < NEURON_NB) begin
                    x.feat[l] = WIDTH'(b * 16 + l);
                    x.wgt[l]  = (wgt_mode == 0) ? 16'd1 : WIDTH'((sel * NUM_BEATS + b) * 256 + l);
                end else begin
                    x.feat[l] = '0;
                    x.wgt[l]  = '0;
                end
            end
            exp_q.push_back(x);
        end
    endtask

    task automatic do_start(input int sel);
        bus.neuron_sel = 4'(sel);
        bus.start      = 1'b1;
        @(negedge clk);
        bus.start      = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int n = 0;
        while (done_cnt < target && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("pass_done_count", LW'(done_cnt), LW'(target));
        repeat (2) @(negedge clk);
    endtask

    always @(negedge clk) begin
        cyc++;
        if (!reset) begin
            first_en   = -1;
            en_in_pass = 0;
            prev_full  = 1'b0;
        end else begin
            if (bus.en) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_en actual addr=%0d required no beat", bus.addr);
                end else begin
                    got = exp_q.pop_front();
                    chk("beat_addr", LW'(bus.addr), LW'(got.addr));
                    chk("beat_in_data", bus.in_data, got.feat);
                    chk("beat_weight", bus.weight, got.wgt);
                end
                if (first_en < 0) first_en = cyc;
                last_en = cyc;
                en_in_pass++;
            end
            if (bus.full_data) begin
                full_cnt++;
                chk("drain_gap", LW'(cyc - last_en), LW'(DRAIN + 1));
                chk("en_span", LW'(last_en - first_en), LW'(exp_span));
                chk("en_count", LW'(en_in_pass), LW'(NUM_BEATS));
            end
            if (bus.done) begin
                done_cnt++;
                chk("done_after_full", LW'(prev_full), LW'(1));
                first_en   = -1;
                en_in_pass = 0;
            end
            prev_full = bus.full_data;
        end
    end

    initial begin
        for (int b = 0; b < 8; b++)
            for (int l = 0; l < IN_SIZE; l++)
                feat_mem[b][l] = WIDTH'(b * 16 + l);
        fill_wgt(0);
        bus.start = 1'b0;
        bus.hold = 1'b0;
        bus.neuron_sel = '0;

        // Reset with random inputs, then idle after release
        repeat (4) begin
            @(negedge clk);
            bus.start      = 1'($urandom);
            bus.hold       = 1'($urandom);
            bus.neuron_sel = 4'($urandom);
        end
        #1 check_zero("reset_outputs");
        @(negedge clk);
        bus.start = 1'b0;
        bus.hold = 1'b0;
        bus.neuron_sel = '0;
        reset = 1'b1;
        repeat (5) @(negedge clk);
        check_zero("idle_outputs");

        // Basic pass, unit weights
        push_pass(0);
        exp_span = 6;
        do_start(0);
        wait_done(1);

        // Row select 5, sel changed mid-pass
        fill_wgt(1);
        push_pass(5);
        do_start(5);
        chk("wgt_addr_b0", LW'(bus.wgt_addr), LW'(35));
        bus.neuron_sel = 4'd9;
        for (int b = 1; b < NUM_BEATS; b++) begin
            @(negedge clk);
            chk("wgt_addr_seq", LW'(bus.wgt_addr), LW'(35 + b));
            chk("feat_addr_seq", LW'(bus.feat_addr), LW'(b));
        end
        wait_done(2);

        // Hold for 3 cycles after beat 2 issue
        push_pass(3);
        exp_span = 9;
        do_start(3);
        repeat (3) @(negedge clk);
        bus.hold = 1'b1;
        repeat (3) @(negedge clk);
        bus.hold = 1'b0;
        wait_done(3);

        // Start held high through the pass and one cycle past DONE: exactly two passes
        push_pass(2);
        push_pass(2);
        exp_span = 6;
        bus.neuron_sel = 4'd2;
        bus.start = 1'b1;
        repeat (15) @(negedge clk);
        bus.start = 1'b0;
        wait_done(5);
        chk("full_count_b2b", LW'(full_cnt), LW'(5));

        // Reset during beat 4
        push_pass(1);
        do_start(1);
        repeat (6) @(negedge clk);
        #2 reset = 1'b0;
        #1 check_zero("async_reset");
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (20) @(negedge clk);
        chk("no_full_after_reset", LW'(full_cnt), LW'(5));
        chk("no_done_after_reset", LW'(done_cnt), LW'(5));
        chk("idle_after_reset", LW'(bus.busy), LW'(0));

        // Recovery pass
        push_pass(7);
        do_start(7);
        wait_done(6);
        chk("queue_empty", LW'(exp_q.size()), LW'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
